// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage program-counter unit.
// Holds the next-PC select encodings and the default reset and trap vectors.
package pc_pkg;

    typedef enum logic [2:0] {
        PC_SEQ    = 3'b000,
        PC_BRANCH = 3'b001,
        PC_JUMP   = 3'b010,
        PC_CALL   = 3'b011,
        PC_RETURN = 3'b100,
        PC_TRAP   = 3'b101
    } pc_src_e;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

endpackage

// File: rtl/return_stack.sv
// Circular return-address stack. A push when full overwrites the oldest entry.
// The overflow flag is sticky until reset.
module return_stack #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [XLEN-1:0]              din,
    output logic [XLEN-1:0]              top,
    output logic [$clog2(RAS_DEPTH):0]   count,
    output logic                         full,
    output logic                         empty,
    output logic                         overflow
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] mem [RAS_DEPTH];
    logic [PW-1:0]   top_ptr;
    logic [PW-1:0]   next_ptr;
    logic [CW-1:0]   cnt;
    logic            ovf;

    assign next_ptr = top_ptr + PW'(1);
    assign full     = (cnt == CW'(RAS_DEPTH));
    assign empty    = (cnt == '0);
    assign top      = mem[top_ptr];
    assign count    = cnt;
    assign overflow = ovf;

    // Pointer wraps naturally; on a full push the slot it lands on is the oldest entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            top_ptr <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
        end else if (push) begin
            top_ptr <= next_ptr;
            if (full) begin
                ovf <= 1'b1;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end else if (pop && !empty) begin
            top_ptr <= top_ptr - PW'(1);
            cnt     <= cnt - CW'(1);
        end
    end

    // Storage carries no reset; only valid entries below count are ever read back.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[next_ptr] <= din;
        end
    end

endmodule

// File: rtl/pc_unit_ras.sv
// Program-counter unit with return-address stack and trap redirect.
// Selects the next PC each cycle from the control FSM's pc_src and enables.
module pc_unit_ras
    import pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEFAULT_TRAP_VECTOR),
    parameter int              RAS_DEPTH    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         pc_write,
    input  logic                         pc_write_cond,
    input  logic                         zero,
    input  logic [2:0]                   pc_src,
    input  logic [XLEN-1:0]              seq_value,
    input  logic [XLEN-1:0]              branch_target,
    input  logic [XLEN-1:0]              jump_offset,
    input  logic [XLEN-1:0]              return_addr,
    output logic [XLEN-1:0]              pc,
    output logic [XLEN-1:0]              epc,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_overflow,
    output logic                         ras_underflow
);

    logic            en;
    logic            push;
    logic            pop;
    logic            ras_empty;
    logic [XLEN-1:0] ras_top;
    pc_src_e         src;

    always_comb begin
        src  = pc_src_e'(pc_src);
        en   = pc_write | (pc_write_cond & zero);
        push = en && (src == PC_CALL);
        pop  = en && (src == PC_RETURN) && !ras_empty;
    end

    return_stack #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .din      (return_addr),
        .top      (ras_top),
        .count    (ras_count),
        .full     (),
        .empty    (ras_empty),
        .overflow (ras_overflow)
    );

    // SEQ only advances on the unconditional enable; reserved encodings leave state alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc            <= RESET_VECTOR;
            epc           <= '0;
            ras_underflow <= 1'b0;
        end else begin
            ras_underflow <= 1'b0;
            if (en) begin
                case (src)
                    PC_SEQ: begin
                        if (pc_write) pc <= seq_value;
                    end
                    PC_BRANCH: pc <= branch_target;
                    PC_JUMP,
                    PC_CALL:   pc <= pc + jump_offset;
                    PC_RETURN: begin
                        if (!ras_empty) begin
                            pc <= ras_top;
                        end else begin
                            pc            <= TRAP_VECTOR;
                            epc           <= pc;
                            ras_underflow <= 1'b1;
                        end
                    end
                    PC_TRAP: begin
                        pc  <= TRAP_VECTOR;
                        epc <= pc;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
